// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle floating-point adder/subtractor, round to nearest even.
// One operation in flight at a time. Stages: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> DONE.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high;
//   in_ready is high only in IDLE; out_valid is high only in DONE and s/flags stay
//   stable until the edge where out_ready is high.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake; a, b, op captured on accept (op=1 -> A-B)
//   out_valid/out_ready result handshake; s is the result
//   flag_ovf/unf/inv    overflow to inf / flush to zero / invalid (NaN made)
//   dbg_state           current FSM state, for observation only
module fp_addsub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] s,
  output logic         flag_ovf,
  output logic         flag_unf,
  output logic         flag_inv,
  output logic [2:0]   dbg_state
);
  // Datapath layout: carry | hidden | MAN_W mantissa | guard | round | sticky
  localparam int M      = MAN_W + 5;
  localparam int SH_MAX = MAN_W + 3;
  localparam int EW     = EXP_W + 2;  // signed exponent with room for under/overflow
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [W-1:0]         a_q, a_d, b_q, b_d;
  logic                 spec_q, spec_d, spec_inv_q, spec_inv_d;
  logic [W-1:0]         spec_res_q, spec_res_d;
  logic                 sign_q, sign_d, sub_q, sub_d;
  logic                 zero_q, zero_d, unf_pend_q, unf_pend_d;
  logic signed [EW-1:0] exp_q, exp_d;
  logic [M-1:0]         mbig_q, mbig_d, msml_q, msml_d, man_q, man_d;
  logic [W-1:0]         s_q, s_d;
  logic                 ovf_q, ovf_d, unf_q, unf_d, inv_q, inv_d;

  // Combinational temporaries
  logic [EXP_W-1:0]     ea, eb, e_big, e_sml, diff;
  logic [MAN_W-1:0]     ma, mb, m_big, m_sml;
  logic                 a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_ge;
  logic [M-1:0]         ext_sml, sum;
  int                   sh, lz;
  logic signed [EW-1:0] exp_n;
  logic [MAN_W:0]       mr;
  logic [MAN_W+1:0]     rnd;
  logic [MAN_W-1:0]     man_f;
  logic                 rnd_up;

  function automatic int lzc(input logic [M-2:0] v);
    lzc = M - 1;
    for (int i = 0; i <= M - 2; i++) begin
      if (v[i]) lzc = M - 2 - i;  // ascending scan: the highest set bit wins
    end
  endfunction

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    spec_d     = spec_q;
    spec_inv_d = spec_inv_q;
    spec_res_d = spec_res_q;
    sign_d     = sign_q;
    sub_d      = sub_q;
    zero_d     = zero_q;
    unf_pend_d = unf_pend_q;
    exp_d      = exp_q;
    mbig_d     = mbig_q;
    msml_d     = msml_q;
    man_d      = man_q;
    s_d        = s_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    inv_d      = inv_q;

    ea     = a_q[W-2:MAN_W];
    eb     = b_q[W-2:MAN_W];
    ma     = a_q[MAN_W-1:0];
    mb     = b_q[MAN_W-1:0];
    a_nan  = (&ea) & (|ma);
    b_nan  = (&eb) & (|mb);
    a_inf  = (&ea) & ~(|ma);
    b_inf  = (&eb) & ~(|mb);
    a_zero = ~(|ea);
    b_zero = ~(|eb);
    a_ge   = ({ea, ma} >= {eb, mb});
    e_big  = a_ge ? ea : eb;
    e_sml  = a_ge ? eb : ea;
    m_big  = a_ge ? ma : mb;
    m_sml  = a_ge ? mb : ma;
    diff   = e_big - e_sml;
    sh     = (int'(diff) > SH_MAX) ? SH_MAX : int'(diff);
    ext_sml = {2'b01, m_sml, 3'b000};
    sum    = sub_q ? (mbig_q - msml_q) : (mbig_q + msml_q);
    lz     = lzc(man_q[M-2:0]);
    exp_n  = exp_q;
    mr     = man_q[M-2:3];
    rnd_up = man_q[2] & (man_q[1] | man_q[0] | mr[0]);
    rnd    = {1'b0, mr} + {{(MAN_W+1){1'b0}}, rnd_up};
    man_f  = rnd[MAN_W-1:0];

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = {b[W-1] ^ op, b[W-2:0]};
          ovf_d      = 1'b0;
          unf_d      = 1'b0;
          inv_d      = 1'b0;
          zero_d     = 1'b0;
          unf_pend_d = 1'b0;
          state_d    = S_ALIGN;
        end
      end
      S_ALIGN: begin
        // Special operands bypass the arithmetic and are forwarded to ROUND.
        spec_d     = 1'b1;
        spec_inv_d = 1'b0;
        spec_res_d = a_q;
        if (a_nan || b_nan)                          spec_res_d = QNAN;
        else if (a_inf && b_inf && (a_q[W-1] != b_q[W-1])) begin
          spec_res_d = QNAN;
          spec_inv_d = 1'b1;
        end
        else if (a_inf)                              spec_res_d = a_q;
        else if (b_inf)                              spec_res_d = b_q;
        else if (a_zero && b_zero)                   spec_res_d = {a_q[W-1] & b_q[W-1], {(W-1){1'b0}}};
        else if (a_zero)                             spec_res_d = b_q;
        else if (b_zero)                             spec_res_d = a_q;
        else                                         spec_d = 1'b0;
        sign_d  = a_ge ? a_q[W-1] : b_q[W-1];
        sub_d   = a_q[W-1] ^ b_q[W-1];
        exp_d   = $signed({2'b00, e_big});
        mbig_d  = {2'b01, m_big, 3'b000};
        // Bits shifted past the LSB collapse into sticky.
        msml_d  = (ext_sml >> sh) |
                  {{(M-1){1'b0}}, |(ext_sml & ~({M{1'b1}} << sh))};
        state_d = S_ADD;
      end
      S_ADD: begin
        man_d = sum;
        if (sum == '0) begin
          zero_d = 1'b1;  // exact cancellation gives +0
          sign_d = 1'b0;
        end
        state_d = S_NORM;
      end
      S_NORM: begin
        if (!zero_q) begin
          if (man_q[M-1]) begin
            man_d = {1'b0, man_q[M-1:2], |man_q[1:0]};
            exp_n = exp_q + EW'(1);
          end else begin
            man_d = man_q << lz;
            exp_n = exp_q - EW'(lz);
          end
          exp_d = exp_n;
          if (exp_n <= 0) begin
            zero_d     = 1'b1;
            unf_pend_d = 1'b1;
          end
        end
        state_d = S_NORM == S_NORM ? S_ROUND : S_ROUND;
      end
      S_ROUND: begin
        exp_n = exp_q;
        if (rnd[MAN_W+1]) begin
          exp_n = exp_q + EW'(1);  // 1.11..1 rounded up to 10.00..0
          man_f = rnd[MAN_W:1];
        end
        if (spec_q) begin
          s_d   = spec_res_q;
          inv_d = spec_inv_q;
        end else if (zero_q) begin
          s_d   = {sign_q, {(W-1){1'b0}}};
          unf_d = unf_pend_q;
        end else if (exp_n >= EMAX) begin
          s_d   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          ovf_d = 1'b1;
        end else begin
          s_d   = {sign_q, exp_n[EXP_W-1:0], man_f};
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      spec_q     <= 1'b0;
      spec_inv_q <= 1'b0;
      spec_res_q <= '0;
      sign_q     <= 1'b0;
      sub_q      <= 1'b0;
      zero_q     <= 1'b0;
      unf_pend_q <= 1'b0;
      exp_q      <= '0;
      mbig_q     <= '0;
      msml_q     <= '0;
      man_q      <= '0;
      s_q        <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      inv_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      spec_q     <= spec_d;
      spec_inv_q <= spec_inv_d;
      spec_res_q <= spec_res_d;
      sign_q     <= sign_d;
      sub_q      <= sub_d;
      zero_q     <= zero_d;
      unf_pend_q <= unf_pend_d;
      exp_q      <= exp_d;
      mbig_q     <= mbig_d;
      msml_q     <= msml_d;
      man_q      <= man_d;
      s_q        <= s_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      inv_q      <= inv_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign s         = s_q;
  assign flag_ovf  = ovf_q;
  assign flag_unf  = unf_q;
  assign flag_inv  = inv_q;
  assign dbg_state = state_q;
endmodule
